mdu_iter: RTL and testbench

//  Iterative RV64M/RV32M multiply/divide unit; multi-cycle companion to the single-cycle ALU in EX.

---
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_iter.sv | 191 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/response bundle for the iterative multiply/divide unit
interface mdu_iter_if #(
    parameter int XLEN = 64
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] res_o;
    logic            busy_o;

    modport slave (
        input  req_valid_i, op_i, word_i, rs1_i, rs2_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, res_o, busy_o
    );

    modport master (
        output req_valid_i, op_i, word_i, rs1_i, rs2_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, res_o, busy_o
    );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - radix-2 iterative RV64M/RV32M multiply/divide unit
module mdu_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mdu_iter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              is_rem_q, is_rem_d;
    logic              hi_q, hi_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   dq_q, dq_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              word_in, div_in, rem_in, hi_in;
    logic              a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic [XLEN-1:0]   a_in, b_in, a_mag_in, b_mag_in, min_in, spec_res;
    logic              b_zero_in, ovf_in, special_in;
    logic              accept, last;
    logic [CNT_W-1:0]  last_cnt;

    logic [2*XLEN-1:0] acc_step, prod_s;
    logic [XLEN:0]     r_sh;
    logic              r_ge;
    logic [XLEN-1:0]   rem_step, dq_step, quo_s, rem_s, res_calc;

    // Widen a 32-bit value to XLEN, sign- or zero-extending from bit 31.
    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] x, input logic s);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) r[i] = s & x[31];
        return r;
    endfunction

    always_comb begin
        word_in  = (XLEN > 32) ? bus.word_i : 1'b0;
        div_in   = bus.op_i[2];
        rem_in   = bus.op_i[2] & bus.op_i[1];
        // W forms of MULH* collapse to MULW.
        hi_in    = ~bus.op_i[2] & (bus.op_i[1:0] != 2'b00) & ~word_in;
        a_sgn_in = div_in ? ~bus.op_i[0] : (hi_in & (bus.op_i[1:0] != 2'b11));
        b_sgn_in = div_in ? ~bus.op_i[0] : (hi_in & (bus.op_i[1:0] == 2'b01));
        a_in     = word_in ? ext_w(bus.rs1_i, a_sgn_in) : bus.rs1_i;
        b_in     = word_in ? ext_w(bus.rs2_i, b_sgn_in) : bus.rs2_i;
        a_neg_in = a_sgn_in & a_in[XLEN-1];
        b_neg_in = b_sgn_in & b_in[XLEN-1];
        a_mag_in = a_neg_in ? -a_in : a_in;
        b_mag_in = b_neg_in ? -b_in : b_in;

        min_in   = '0;
        min_in[XLEN-1] = 1'b1;
        if (word_in) min_in = ext_w(XLEN'(32'h8000_0000), 1'b1);

        b_zero_in  = (b_in == '0);
        ovf_in     = div_in & a_sgn_in & (a_in == min_in) & (b_in == '1);
        special_in = div_in & (b_zero_in | ovf_in);
        if (rem_in) spec_res = b_zero_in ? a_in : '0;
        else        spec_res = b_zero_in ? '1 : a_in;
        if (word_in) spec_res = ext_w(spec_res, 1'b1);

        accept   = bus.req_valid_i & (state_q == S_IDLE) & ~bus.flush_i;
        last_cnt = word_q ? CNT_W'(31) : CNT_W'(XLEN - 1);
        last     = (cnt_q == last_cnt);

        // One shift-add and one restoring-divide step per cycle.
        acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
        r_sh     = {rem_q, dq_q[XLEN-1]};
        r_ge     = (r_sh >= {1'b0, divisor_q});
        rem_step = r_ge ? XLEN'(r_sh - {1'b0, divisor_q}) : r_sh[XLEN-1:0];
        dq_step  = {dq_q[XLEN-2:0], r_ge};

        prod_s = neg_q  ? -acc_step : acc_step;
        quo_s  = neg_q  ? -dq_step  : dq_step;
        rem_s  = rneg_q ? -rem_step : rem_step;
        if (is_div_q) res_calc = is_rem_q ? rem_s : quo_s;
        else          res_calc = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        if (word_q) res_calc = ext_w(res_calc, 1'b1);

        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        is_rem_d  = is_rem_q;
        hi_d      = hi_q;
        word_d    = word_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        res_d     = res_q;

        if (accept) begin
            cnt_d     = '0;
            is_div_d  = div_in;
            is_rem_d  = rem_in;
            hi_d      = hi_in;
            word_d    = word_in;
            neg_d     = a_neg_in ^ b_neg_in;
            rneg_d    = a_neg_in;
            acc_d     = '0;
            mcand_d   = {{XLEN{1'b0}}, a_mag_in};
            mplier_d  = b_mag_in;
            // Top-align a 32-bit dividend so the first N steps consume it.
            dq_d      = word_in ? (a_mag_in << (XLEN - 32)) : a_mag_in;
            rem_d     = '0;
            divisor_d = b_mag_in;
            if (special_in) res_d = spec_res;
        end else if (state_q == S_CALC) begin
            cnt_d    = cnt_q + CNT_W'(1);
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            dq_d     = dq_step;
            rem_d    = rem_step;
            if (last && !bus.flush_i) res_d = res_calc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = special_in ? S_DONE : S_CALC;
            S_CALC:  if (last) state_d = S_DONE;
            S_DONE:  if (bus.resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i) state_d = S_IDLE;
    end

    always_comb begin
        bus.req_ready_o  = (state_q == S_IDLE) & ~bus.flush_i;
        bus.resp_valid_o = (state_q == S_DONE);
        bus.busy_o       = (state_q != S_IDLE);
        bus.res_o        = res_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            hi_q      <= 1'b0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            res_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            is_rem_q  <= is_rem_d;
            hi_q      <= hi_d;
            word_q    <= word_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            res_q     <= res_d;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter with a behavioural RV64M model
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(64)) bus();
    mdu_iter #(.XLEN(64), .CNT_W(7)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];
    bit          rr_rand  = 1'b0;
    bit          rr_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        bus.resp_ready_i = rr_rand ? ($urandom_range(3) != 0) : rr_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    // RV64M semantics written with plain SV arithmetic.
    task automatic model(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output int lat);
        logic [127:0]       pa, pb, p;
        logic signed [63:0] sa, sb, sq;
        logic signed [31:0] sa32, sb32, sq32;
        logic [31:0]        a32, b32, t32;
        bit                 dz, ov;
        a32 = a[31:0]; b32 = b[31:0];
        sa = a; sb = b; sa32 = a32; sb32 = b32;
        if (w) begin
            dz = (b32 == 32'd0);
            ov = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
            case (op)
                3'b100: if (dz) t32 = '1; else if (ov) t32 = a32; else begin sq32 = sa32 / sb32; t32 = sq32; end
                3'b101: if (dz) t32 = '1; else t32 = a32 / b32;
                3'b110: if (dz) t32 = a32; else if (ov) t32 = '0; else begin sq32 = sa32 % sb32; t32 = sq32; end
                3'b111: if (dz) t32 = a32; else t32 = a32 % b32;
                default: t32 = a32 * b32;
            endcase
            r   = {{32{t32[31]}}, t32};
            lat = (op[2] && (dz || (ov && !op[0]))) ? 1 : 33;
        end else begin
            dz = (b == 64'd0);
            ov = (a == 64'h8000_0000_0000_0000) && (b == '1);
            case (op)
                3'b000: r = a * b;
                3'b001: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; r = p[127:64]; end
                3'b010: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       p = pa * pb; r = p[127:64]; end
                3'b011: begin pa = {64'd0, a};       pb = {64'd0, b};       p = pa * pb; r = p[127:64]; end
                3'b100: if (dz) r = '1; else if (ov) r = a; else begin sq = sa / sb; r = sq; end
                3'b101: if (dz) r = '1; else r = a / b;
                3'b110: if (dz) r = a; else if (ov) r = '0; else begin sq = sa % sb; r = sq; end
                default: if (dz) r = a; else r = a % b;
            endcase
            lat = (op[2] && (dz || (ov && !op[0]))) ? 1 : 65;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input bit push, input logic [63:0] er, input int el, output int t_acc);
        int k = 0;
        bus.op_i = op; bus.word_i = w; bus.rs1_i = a; bus.rs2_i = b;
        bus.req_valid_i = 1'b1;
        #1;
        while (!bus.req_ready_o && k < 300) begin
            @(negedge clk); #1; k++;
        end
        t_acc = cyc;
        if (!bus.req_ready_o) begin
            bad("ready_timeout");
            bus.req_valid_i = 1'b0;
            return;
        end
        if (push) begin
            exp_q.push_back(er);
            lat_q.push_back(cyc + el);
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic issue_m(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        int          lat, t;
        model(op, w, a, b, r, lat);
        issue(op, w, a, b, 1'b1, r, lat, t);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk); k++;
        end
        if (exp_q.size() != 0) begin
            bad("drain_timeout");
            exp_q.delete();
            lat_q.delete();
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd_opnd();
        logic [63:0] v;
        case ($urandom_range(6))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = {$urandom, 32'h8000_0000};
            4:       v = 64'($urandom_range(15));
            5:       v = -64'($urandom_range(15));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Monitor: latency on the rising edge of resp_valid, stability under backpressure, value at handshake.
    initial begin
        bit          prev_v = 1'b0;
        logic [63:0] hold   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (bus.resp_valid_o) begin
                    if (!prev_v) begin
                        if (exp_q.size() == 0) bad("unexpected_resp");
                        else chk("latency", 64'(cyc), 64'(lat_q[0]));
                        hold = bus.res_o;
                    end else begin
                        chk("res_stable", bus.res_o, hold);
                    end
                    if (bus.resp_ready_i && exp_q.size() != 0) begin
                        chk("result", bus.res_o, exp_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
                prev_v = bus.resp_valid_o && !bus.resp_ready_i;
            end
        end
    end

    initial begin
        int t, t2, k;
        bus.req_valid_i = 1'b0; bus.op_i = '0; bus.word_i = 1'b0;
        bus.rs1_i = '0; bus.rs2_i = '0; bus.flush_i = 1'b0; bus.resp_ready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_res", bus.res_o, 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        #1 rst = 1'b0;
        bus.flush_i = 1'b1;
        #1 chk("idle_flush_ready", 64'(bus.req_ready_o), 64'd0);
        bus.flush_i = 1'b0;
        @(negedge clk); #1;

        // 7 * -3 under 20+ cycles of backpressure
        rr_force = 1'b0;
        issue(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 65, t);
        k = 0;
        while (!bus.resp_valid_o && k < 200) begin @(negedge clk); k++; end
        if (!bus.resp_valid_o) bad("bp_wait_valid");
        repeat (20) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
            chk("bp_resp_valid", 64'(bus.resp_valid_o), 64'd1);
        end
        rr_force = 1'b1;
        drain();

        issue(3'b011, 1'b0, '1, '1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65, t);
        issue(3'b010, 1'b0, '1, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65, t);
        issue(3'b100, 1'b0, -64'd7, 64'd2, 1'b1, -64'd3, 65, t);
        issue(3'b110, 1'b0, -64'd7, 64'd2, 1'b1, -64'd1, 65, t);
        issue(3'b100, 1'b1, 64'h1_0000_0010, 64'd4, 1'b1, 64'd4, 33, t);
        issue(3'b101, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, '1, 1, t);
        issue(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 64'd0, 1, t);
        issue(3'b100, 1'b1, 64'h8000_0000, '1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1, t);
        issue(3'b111, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'h7_0000_0000, 1'b1, 64'hFFFF_FFFF_8000_0005, 1, t);
        issue(3'b001, 1'b1, 64'h1_0000_0003, 64'd5, 1'b1, 64'd15, 33, t);
        issue(3'b101, 1'b1, 64'hFFFF_FFFF, 64'd2, 1'b1, 64'h7FFF_FFFF, 33, t);
        drain();

        // flush mid-divide, then immediate re-accept
        issue(3'b100, 1'b0, 64'd12345678, 64'd7, 1'b0, '0, 0, t);
        k = 0;
        while (cyc != t + 10 && k < 100) begin @(negedge clk); k++; end
        #1 bus.flush_i = 1'b1;
        #1 chk("flush_req_ready", 64'(bus.req_ready_o), 64'd0);
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy_o), 64'd0);
        chk("flush_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        #1 bus.flush_i = 1'b0;
        issue(3'b100, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 65, t2);
        chk("flush_reaccept_cycle", 64'(t2), 64'(t + 11));
        drain();

        // reset in the middle of CALC
        issue(3'b101, 1'b0, 64'd999, 64'd10, 1'b0, '0, 0, t);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        chk("mid_rst_res", bus.res_o, 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        #1 rst = 1'b0;
        issue_m(3'b111, 1'b0, 64'd999, 64'd10);
        drain();

        // randomized traffic with random backpressure
        rr_rand = 1'b1;
        repeat (150) begin
            issue_m(3'($urandom_range(7)), 1'($urandom_range(1)), rnd_opnd(), rnd_opnd());
        end
        drain();
        rr_rand = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
